// File: rtl/can_frame_decoder.sv
// Destuffed CAN 2.0A/2.0B bitstream to frame fields; CRC-15 check built only with CAN_RX_CRC_CHECK_EN.
// Results and pulses appear one cycle after the sample_point of the deciding bit; no backpressure, every strobe consumes a bit.
module can_frame_decoder #(
    parameter int MAX_BYTES = 8,
    parameter int EOF_BITS  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sampled_bit,
    input  logic                   sample_point,
    output logic [28:0]            rx_id,
    output logic                   rx_ide,
    output logic                   rx_rtr,
    output logic [3:0]             rx_dlc,
    output logic [MAX_BYTES*8-1:0] rx_data,
    output logic [14:0]            rx_crc,
    output logic                   rx_crc_err,
    output logic                   rx_form_err,
    output logic                   rx_done,
    output logic                   rx_busy
);

    localparam int DW = MAX_BYTES * 8;
    localparam logic [7:0] EOF_LAST = 8'(EOF_BITS - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ID_A    = 4'd1;
    localparam logic [3:0] S_BIT_A   = 4'd2;
    localparam logic [3:0] S_IDE     = 4'd3;
    localparam logic [3:0] S_ID_B    = 4'd4;
    localparam logic [3:0] S_RTR_X   = 4'd5;
    localparam logic [3:0] S_R1      = 4'd6;
    localparam logic [3:0] S_R0      = 4'd7;
    localparam logic [3:0] S_DLC     = 4'd8;
    localparam logic [3:0] S_DATA    = 4'd9;
    localparam logic [3:0] S_CRC     = 4'd10;
    localparam logic [3:0] S_CRC_DEL = 4'd11;
    localparam logic [3:0] S_ACK     = 4'd12;
    localparam logic [3:0] S_ACK_DEL = 4'd13;
    localparam logic [3:0] S_EOF     = 4'd14;
    localparam logic [3:0] S_RECOVER = 4'd15;

    logic [3:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [28:0]   id_q, id_d;
    logic          bit_a_q, bit_a_d;
    logic          ide_q, ide_d;
    logic          rtr_q, rtr_d;
    logic [3:0]    dlc_q, dlc_d;
    logic [3:0]    nbytes_q, nbytes_d;
    logic [DW-1:0] data_q, data_d;
    logic [14:0]   crc_rx_q, crc_rx_d;

    logic [28:0]   rx_id_q, rx_id_d;
    logic          rx_ide_q, rx_ide_d;
    logic          rx_rtr_q, rx_rtr_d;
    logic [3:0]    rx_dlc_q, rx_dlc_d;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic [14:0]   rx_crc_q, rx_crc_d;
    logic          rx_crc_err_q, rx_crc_err_d;
    logic          rx_form_err_q, rx_form_err_d;
    logic          rx_done_q, rx_done_d;
    logic          rx_busy_q, rx_busy_d;

    logic          crc_en, crc_clr, crc_cmp, form_hit;
    logic          frame_crc_err;
    logic [5:0]    data_bit_pos;
    logic          data_last;

    // First received bit of each byte lands in its MSB; bytes beyond MAX_BYTES shift out of range.
    assign data_bit_pos = {cnt_q[5:3], ~cnt_q[2:0]};
    assign data_last    = (cnt_q + 8'd1) == {1'b0, nbytes_q, 3'b000};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        id_d          = id_q;
        bit_a_d       = bit_a_q;
        ide_d         = ide_q;
        rtr_d         = rtr_q;
        dlc_d         = dlc_q;
        nbytes_d      = nbytes_q;
        data_d        = data_q;
        crc_rx_d      = crc_rx_q;
        rx_id_d       = rx_id_q;
        rx_ide_d      = rx_ide_q;
        rx_rtr_d      = rx_rtr_q;
        rx_dlc_d      = rx_dlc_q;
        rx_data_d     = rx_data_q;
        rx_crc_d      = rx_crc_q;
        rx_crc_err_d  = rx_crc_err_q;
        rx_form_err_d = 1'b0;
        rx_done_d     = 1'b0;
        rx_busy_d     = rx_busy_q;
        crc_en        = 1'b0;
        crc_clr       = 1'b0;
        crc_cmp       = 1'b0;
        form_hit      = 1'b0;

        if (sample_point) begin
            case (state_q)
                S_IDLE: begin
                    if (!sampled_bit) begin
                        state_d   = S_ID_A;
                        cnt_d     = '0;
                        id_d      = '0;
                        bit_a_d   = 1'b0;
                        ide_d     = 1'b0;
                        rtr_d     = 1'b0;
                        dlc_d     = '0;
                        nbytes_d  = '0;
                        data_d    = '0;
                        crc_rx_d  = '0;
                        crc_clr   = 1'b1;
                        rx_busy_d = 1'b1;
                    end
                end
                S_ID_A: begin
                    crc_en = 1'b1;
                    id_d   = {id_q[27:0], sampled_bit};
                    if (cnt_q == 8'd10) begin
                        state_d = S_BIT_A;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_BIT_A: begin
                    crc_en  = 1'b1;
                    bit_a_d = sampled_bit;
                    state_d = S_IDE;
                end
                S_IDE: begin
                    crc_en = 1'b1;
                    ide_d  = sampled_bit;
                    if (!sampled_bit) begin
                        rtr_d   = bit_a_q;
                        state_d = S_R0;
                    end else begin
                        state_d = S_ID_B;
                    end
                end
                S_ID_B: begin
                    crc_en = 1'b1;
                    id_d   = {id_q[27:0], sampled_bit};
                    if (cnt_q == 8'd17) begin
                        state_d = S_RTR_X;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_RTR_X: begin
                    crc_en  = 1'b1;
                    rtr_d   = sampled_bit;
                    state_d = S_R1;
                end
                S_R1: begin
                    crc_en  = 1'b1;
                    state_d = S_R0;
                end
                S_R0: begin
                    crc_en  = 1'b1;
                    state_d = S_DLC;
                end
                S_DLC: begin
                    crc_en = 1'b1;
                    dlc_d  = {dlc_q[2:0], sampled_bit};
                    if (cnt_q == 8'd3) begin
                        cnt_d = '0;
                        if (rtr_q) begin
                            nbytes_d = 4'd0;
                        end else if (dlc_d > 4'd8) begin
                            nbytes_d = 4'd8;
                        end else begin
                            nbytes_d = dlc_d;
                        end
                        state_d = (nbytes_d == 4'd0) ? S_CRC : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_DATA: begin
                    crc_en = 1'b1;
                    data_d = data_q | (DW'(sampled_bit) << data_bit_pos);
                    if (data_last) begin
                        state_d = S_CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_CRC: begin
                    crc_rx_d = {crc_rx_q[13:0], sampled_bit};
                    if (cnt_q == 8'd14) begin
                        state_d = S_CRC_DEL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_CRC_DEL: begin
                    if (!sampled_bit) begin
                        form_hit = 1'b1;
                    end else begin
                        crc_cmp = 1'b1;
                        state_d = S_ACK;
                    end
                end
                S_ACK: begin
                    state_d = S_ACK_DEL;
                end
                S_ACK_DEL: begin
                    if (!sampled_bit) begin
                        form_hit = 1'b1;
                    end else begin
                        state_d = S_EOF;
                        cnt_d   = '0;
                    end
                end
                S_EOF: begin
                    if (!sampled_bit) begin
                        form_hit = 1'b1;
                    end else if (cnt_q == EOF_LAST) begin
                        state_d      = S_IDLE;
                        cnt_d        = '0;
                        rx_id_d      = id_q;
                        rx_ide_d     = ide_q;
                        rx_rtr_d     = rtr_q;
                        rx_dlc_d     = dlc_q;
                        rx_data_d    = data_q;
                        rx_crc_d     = crc_rx_q;
                        rx_crc_err_d = frame_crc_err;
                        rx_done_d    = 1'b1;
                        rx_busy_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_RECOVER: begin
                    if (!sampled_bit) begin
                        cnt_d = '0;
                    end else if (cnt_q == EOF_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase

            // Output field registers are deliberately untouched so the previous frame stays visible.
            if (form_hit) begin
                state_d       = S_RECOVER;
                cnt_d         = '0;
                rx_form_err_d = 1'b1;
                rx_busy_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            id_q          <= '0;
            bit_a_q       <= 1'b0;
            ide_q         <= 1'b0;
            rtr_q         <= 1'b0;
            dlc_q         <= '0;
            nbytes_q      <= '0;
            data_q        <= '0;
            crc_rx_q      <= '0;
            rx_id_q       <= '0;
            rx_ide_q      <= 1'b0;
            rx_rtr_q      <= 1'b0;
            rx_dlc_q      <= '0;
            rx_data_q     <= '0;
            rx_crc_q      <= '0;
            rx_crc_err_q  <= 1'b0;
            rx_form_err_q <= 1'b0;
            rx_done_q     <= 1'b0;
            rx_busy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            id_q          <= id_d;
            bit_a_q       <= bit_a_d;
            ide_q         <= ide_d;
            rtr_q         <= rtr_d;
            dlc_q         <= dlc_d;
            nbytes_q      <= nbytes_d;
            data_q        <= data_d;
            crc_rx_q      <= crc_rx_d;
            rx_id_q       <= rx_id_d;
            rx_ide_q      <= rx_ide_d;
            rx_rtr_q      <= rx_rtr_d;
            rx_dlc_q      <= rx_dlc_d;
            rx_data_q     <= rx_data_d;
            rx_crc_q      <= rx_crc_d;
            rx_crc_err_q  <= rx_crc_err_d;
            rx_form_err_q <= rx_form_err_d;
            rx_done_q     <= rx_done_d;
            rx_busy_q     <= rx_busy_d;
        end
    end

`ifdef CAN_RX_CRC_CHECK_EN
    logic [14:0] crc_calc_q, crc_calc_d;
    logic        crc_err_q, crc_err_d;
    logic        crc_fb;

    // SOF is dominant, so clearing to zero on SOF is the same as shifting it in.
    always_comb begin
        crc_calc_d = crc_calc_q;
        crc_err_d  = crc_err_q;
        crc_fb     = sampled_bit ^ crc_calc_q[14];
        if (crc_clr) begin
            crc_calc_d = '0;
            crc_err_d  = 1'b0;
        end else if (crc_en) begin
            crc_calc_d = {crc_calc_q[13:0], 1'b0} ^ (crc_fb ? 15'h4599 : 15'h0000);
        end
        if (crc_cmp) begin
            crc_err_d = (crc_calc_q != crc_rx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_calc_q <= '0;
            crc_err_q  <= 1'b0;
        end else begin
            crc_calc_q <= crc_calc_d;
            crc_err_q  <= crc_err_d;
        end
    end

    assign frame_crc_err = crc_err_q;
`else
    logic crc_unused;
    assign crc_unused    = ^{crc_en, crc_clr, crc_cmp};
    assign frame_crc_err = 1'b0;
`endif

    assign rx_id       = rx_id_q;
    assign rx_ide      = rx_ide_q;
    assign rx_rtr      = rx_rtr_q;
    assign rx_dlc      = rx_dlc_q;
    assign rx_data     = rx_data_q;
    assign rx_crc      = rx_crc_q;
    assign rx_crc_err  = rx_crc_err_q;
    assign rx_form_err = rx_form_err_q;
    assign rx_done     = rx_done_q;
    assign rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_can_frame_decoder.sv
// Scoreboard bench for can_frame_decoder: a bit-level frame model builds each frame and its expected result.
module tb_can_frame_decoder;

    localparam int MB   = 4;
    localparam int EOFB = 7;
    localparam int DW   = MB * 8;
`ifdef CAN_RX_CRC_CHECK_EN
    localparam bit CRC_CHK = 1'b1;
`else
    localparam bit CRC_CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          sampled_bit;
    logic          sample_point;
    logic [28:0]   rx_id;
    logic          rx_ide;
    logic          rx_rtr;
    logic [3:0]    rx_dlc;
    logic [DW-1:0] rx_data;
    logic [14:0]   rx_crc;
    logic          rx_crc_err;
    logic          rx_form_err;
    logic          rx_done;
    logic          rx_busy;

    can_frame_decoder #(.MAX_BYTES(MB), .EOF_BITS(EOFB)) dut (
        .clk(clk), .rst(rst), .sampled_bit(sampled_bit), .sample_point(sample_point),
        .rx_id(rx_id), .rx_ide(rx_ide), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc),
        .rx_data(rx_data), .rx_crc(rx_crc), .rx_crc_err(rx_crc_err),
        .rx_form_err(rx_form_err), .rx_done(rx_done), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_err;
        logic [28:0]   id;
        logic          ide;
        logic          rtr;
        logic [3:0]    dlc;
        logic [DW-1:0] data;
        logic [14:0]   crc;
        logic          crc_err;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_out;
    bit   fb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [14:0] crc_of(input int n);
        logic [14:0] c = '0;
        logic        top;
        for (int i = 0; i < n; i++) begin
            top = fb[i] ^ c[14];
            c   = {c[13:0], 1'b0};
            if (top) c = c ^ 15'h4599;
        end
        return c;
    endfunction

    // Builds the full destuffed bit sequence of one frame into fb and its expected decode.
    task automatic build(input logic [28:0] id, input bit ide, input bit rtr, input logic [3:0] dlc,
                         input logic [63:0] pay, input int flip, output exp_t e);
        int          n;
        logic [14:0] c;
        fb.delete();
        fb.push_back(1'b0);
        if (!ide) begin
            for (int i = 10; i >= 0; i--) fb.push_back(id[i]);
            fb.push_back(rtr); fb.push_back(1'b0); fb.push_back(1'b0);
        end else begin
            for (int i = 28; i >= 18; i--) fb.push_back(id[i]);
            fb.push_back(1'b1); fb.push_back(1'b1);
            for (int i = 17; i >= 0; i--) fb.push_back(id[i]);
            fb.push_back(rtr); fb.push_back(1'b0); fb.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) fb.push_back(dlc[i]);
        n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int b = 0; b < n; b++)
            for (int i = 7; i >= 0; i--) fb.push_back(pay[8*b+i]);
        c = crc_of(fb.size());
        if (flip >= 0) c[flip] = ~c[flip];
        for (int i = 14; i >= 0; i--) fb.push_back(c[i]);
        fb.push_back(1'b1); fb.push_back(1'b0); fb.push_back(1'b1);
        for (int i = 0; i < EOFB; i++) fb.push_back(1'b1);
        e         = '0;
        e.id      = ide ? id : {18'd0, id[10:0]};
        e.ide     = ide;
        e.rtr     = rtr;
        e.dlc     = dlc;
        for (int b = 0; b < n && b < MB; b++) e.data[8*b +: 8] = pay[8*b +: 8];
        e.crc     = c;
        e.crc_err = CRC_CHK && (flip >= 0);
    endtask

    task automatic send_bit(input bit b);
        int gap;
        sampled_bit  = b;
        sample_point = 1'b1;
        @(posedge clk); #1;
        sample_point = 1'b0;
        sampled_bit  = 1'($urandom);
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // err_pos < 0 sends the whole frame; otherwise a dominant bit replaces fb[err_pos], then recovery.
    task automatic send_frame(input int err_pos);
        for (int i = 0; i < fb.size(); i++) begin
            if (i == err_pos) begin
                send_bit(1'b0);
                break;
            end
            send_bit(fb[i]);
            if (i == 0) chk("busy_after_sof", 64'(rx_busy), 64'd1);
        end
        if (err_pos >= 0)
            for (int i = 0; i < EOFB; i++) send_bit(1'b1);
    endtask

    task automatic run_frame(input logic [28:0] id, input bit ide, input bit rtr, input logic [3:0] dlc,
                             input logic [63:0] pay, input int flip, input int err_kind);
        exp_t e;
        int   pos;
        int   len;
        build(id, ide, rtr, dlc, pay, flip, e);
        len = fb.size();
        case (err_kind)
            1:       pos = len - EOFB - 3;
            2:       pos = len - EOFB - 1;
            3:       pos = len - EOFB + $urandom_range(0, EOFB - 1);
            default: pos = -1;
        endcase
        if (pos >= 0) begin
            e        = last_out;
            e.is_err = 1'b1;
            exp_q.push_back(e);
        end else begin
            exp_q.push_back(e);
            last_out = e;
        end
        send_frame(pos);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_id"},      64'(rx_id), 64'd0);
        chk({tag, "_ide"},     64'(rx_ide), 64'd0);
        chk({tag, "_rtr"},     64'(rx_rtr), 64'd0);
        chk({tag, "_dlc"},     64'(rx_dlc), 64'd0);
        chk({tag, "_data"},    64'(rx_data), 64'd0);
        chk({tag, "_crc"},     64'(rx_crc), 64'd0);
        chk({tag, "_crc_err"}, 64'(rx_crc_err), 64'd0);
        chk({tag, "_pulses"},  64'({rx_done, rx_form_err}), 64'd0);
        chk({tag, "_busy"},    64'(rx_busy), 64'd0);
    endtask

    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (rx_done || rx_form_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual done=%0b form_err=%0b required none", rx_done, rx_form_err);
                end else begin
                    m = exp_q.pop_front();
                    chk("event_kind", 64'({rx_form_err, rx_done}), m.is_err ? 64'd2 : 64'd1);
                    chk("busy_at_end", 64'(rx_busy), 64'd0);
                    chk("id",      64'(rx_id), 64'(m.id));
                    chk("ide",     64'(rx_ide), 64'(m.ide));
                    chk("rtr",     64'(rx_rtr), 64'(m.rtr));
                    chk("dlc",     64'(rx_dlc), 64'(m.dlc));
                    chk("data",    64'(rx_data), 64'(m.data));
                    chk("crc",     64'(rx_crc), 64'(m.crc));
                    chk("crc_err", 64'(rx_crc_err), 64'(m.crc_err));
                end
            end
        end
    end

    initial begin
        exp_t dummy;
        int   kind;
        rst          = 1'b1;
        sampled_bit  = 1'b1;
        sample_point = 1'b0;
        last_out     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        repeat (3) send_bit(1'b1);

        run_frame(29'h7DC, 1'b0, 1'b0, 4'd1, 64'hA5, -1, 0);
        run_frame(29'h12345678, 1'b1, 1'b0, 4'd2, 64'hADDE, -1, 0);
        run_frame(29'h7DC, 1'b0, 1'b0, 4'd1, 64'hA5, 5, 0);
        run_frame(29'h7DC, 1'b0, 1'b0, 4'd1, 64'hA5, -1, 1);
        run_frame(29'h7DC, 1'b0, 1'b0, 4'd1, 64'hA5, -1, 0);
        run_frame(29'h123, 1'b0, 1'b1, 4'd4, 64'hFFFF_FFFF, -1, 0);
        run_frame(29'h1ABCDEF1, 1'b1, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, -1, 0);

        build(29'h12345678, 1'b1, 1'b0, 4'd2, 64'hADDE, -1, dummy);
        for (int i = 0; i < 5; i++) send_bit(fb[i]);
        sampled_bit  = fb[5];
        sample_point = 1'b1;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst          = 1'b0;
        sample_point = 1'b0;
        check_zero("mid_reset");
        last_out = '0;
        send_bit(1'b1);
        run_frame(29'h12345678, 1'b1, 1'b0, 4'd2, 64'hADDE, -1, 0);

        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 7);
            run_frame(29'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom),
                      {$urandom, $urandom},
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 14)) : -1,
                      (kind <= 3) ? kind : 0);
            repeat ($urandom_range(0, 2)) send_bit(1'b1);
        end

        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
